// File: rtl/way4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4-way output mux.
// Four requesters (A..D) share one output channel. One requester holds the
// grant at a time, for at most MAX_BURST consecutive cycles. The search for
// the next owner starts at ptr, which always points one past the last pick.
//
// Handshake: req[i] is a level request. While gnt[i] is high, out carries
// source i's data and out_valid is high. A requester keeps req high for as
// long as it wants the channel. A dropped request is seen at the next clock
// edge, and out_valid stays high for the cycle in which the owner drops req.
module way4_rr_arbiter #(
  parameter int WIDTH     = 5,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             dbg_busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;

  logic [7:0]    dbl;
  logic [3:0]    rot;
  logic [1:0]    off;
  logic [1:0]    pick;
  logic          found;

  // Rotate req so that bit 0 corresponds to ptr, then take the lowest set bit.
  // A releasing owner that still requests sits at the far end of the rotation
  // (ptr = owner+1), so it is chosen only when nobody else is asking.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[3:0];
    found = |rot;
    off   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
    pick = ptr + off;
  end

  // Grant FSM: IDLE waits for any request, BUSY holds or re-arbitrates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= BUSY;
            gnt   <= 4'b0001 << pick;
            sel   <= pick;
            cnt   <= CW'(1);
            ptr   <= pick + 2'd1;
          end
        end
        BUSY: begin
          if (req[sel] && (cnt < CW'(MAX_BURST))) begin
            cnt <= cnt + CW'(1);
          end else if (found) begin
            gnt <= 4'b0001 << pick;
            sel <= pick;
            cnt <= CW'(1);
            ptr <= pick + 2'd1;
          end else begin
            state <= IDLE;
            gnt   <= 4'b0000;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output mux: combinational from sel, forced to zero while no grant is held.
  always_comb begin
    out_valid = |gnt;
    dbg_busy  = (state == BUSY);
    out       = '0;
    if (out_valid) begin
      case (sel)
        2'd0:    out = a;
        2'd1:    out = b;
        2'd2:    out = c;
        default: out = d;
      endcase
    end
  end

endmodule

// File: tb/tb_way4_rr_arbiter.sv
// Testbench for way4_rr_arbiter: directed scenarios followed by random traffic,
// all compared against a cycle-level reference model of the arbitration rules.
module tb_way4_rr_arbiter;

  localparam int WIDTH     = 5;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] a, b, c, d;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             dbg_busy;

  way4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid),
    .dbg_busy(dbg_busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner index (-1 = none), search start, burst length.
  int m_owner     = -1;
  int m_ptr       = 0;
  int m_cnt       = 0;
  int m_sel       = 0;
  bit m_sel_known = 1'b1;

  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] data_of(input int i);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  // Apply the arbitration rules for one rising edge using the sampled rst/req.
  task automatic model_edge();
    int  pick;
    bit  found;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_sel_known = 1'b1;
    end else if (m_owner >= 0 && req[m_owner] && m_cnt < MAX_BURST) begin
      m_cnt++;
    end else begin
      found = 1'b0;
      pick  = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && req[(m_ptr + k) % 4]) begin
          found = 1'b1;
          pick  = (m_ptr + k) % 4;
        end
      end
      if (found) begin
        m_owner = pick; m_cnt = 1; m_ptr = (pick + 1) % 4;
        m_sel = pick; m_sel_known = 1'b1;
      end else begin
        m_owner = -1; m_cnt = 0; m_sel_known = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [3:0]       e_gnt;
    logic [WIDTH-1:0] e_out;
    e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e_out = (m_owner < 0) ? '0 : data_of(m_owner);
    check($sformatf("%s.gnt", ctx), 32'(gnt), 32'(e_gnt));
    check($sformatf("%s.out_valid", ctx), 32'(out_valid), 32'(m_owner >= 0));
    check($sformatf("%s.out", ctx), 32'(out), 32'(e_out));
    check($sformatf("%s.busy", ctx), 32'(dbg_busy), 32'(m_owner >= 0));
    if (m_sel_known) check($sformatf("%s.sel", ctx), 32'(sel), 32'(m_sel));
  endtask

  // Driver: present inputs, take one edge, update model, check after settling.
  task automatic step(input string ctx, input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(ctx);
  endtask

  int t3_val[4] = '{8, 6, 4, 2};

  initial begin
    logic [1:0] e_sel;
    logic [3:0] rq;
    logic       rr;
    rst = 1'b1; req = 4'b1111; a = '0; b = '0; c = '0; d = '0;

    // 1: reset with all requests asserted
    step("t1", 1'b1, 4'b1111);
    step("t1", 1'b1, 4'b1111);
    check("t1_gnt_zero", 32'(gnt), 32'd0);
    check("t1_sel_zero", 32'(sel), 32'd0);
    check("t1_out_zero", 32'(out), 32'd0);

    // 2: lone requester C keeps the grant across burst expiry
    c = 5'd4;
    step("t2_rst", 1'b1, 4'b0000);
    for (int i = 0; i < 9; i++) begin
      step("t2", 1'b0, 4'b0100);
      check("t2_gnt_c", 32'(gnt), 32'b0100);
      check("t2_out_c", 32'(out), 32'd4);
    end

    // 3: all four request; bursts of MAX_BURST rotate A,B,C,D,A
    a = 5'd8; b = 5'd6; c = 5'd4; d = 5'd2;
    step("t3_rst", 1'b1, 4'b1111);
    for (int s = 0; s < 5; s++)
      for (int k = 0; k < MAX_BURST; k++) exp_q.push_back(2'(s % 4));
    while (exp_q.size() > 0) begin
      step("t3", 1'b0, 4'b1111);
      e_sel = exp_q.pop_front();
      check("t3_sel_seq", 32'(sel), 32'(e_sel));
      check("t3_out_seq", 32'(out), 32'(t3_val[e_sel]));
      check("t3_valid", 32'(out_valid), 32'd1);
    end

    // 4: A drops after two grant cycles; B takes over with no bubble
    step("t4_rst", 1'b1, 4'b0011);
    step("t4", 1'b0, 4'b0011);
    step("t4", 1'b0, 4'b0011);
    check("t4_gnt_a", 32'(gnt), 32'b0001);
    step("t4", 1'b0, 4'b0010);
    check("t4_gnt_b", 32'(gnt), 32'b0010);
    check("t4_out_b", 32'(out), 32'd6);
    check("t4_valid", 32'(out_valid), 32'd1);

    // 5: reset in the middle of C's burst, then A wins first
    step("t5_rst", 1'b1, 4'b1111);
    for (int i = 0; i < 10; i++) step("t5", 1'b0, 4'b1111);
    check("t5_mid_c", 32'(sel), 32'd2);
    step("t5", 1'b1, 4'b1111);
    check("t5_rst_gnt", 32'(gnt), 32'd0);
    step("t5", 1'b0, 4'b1111);
    check("t5_gnt_a", 32'(gnt), 32'b0001);

    // 6: owner drops with nobody waiting -> idle; then D requests
    step("t6", 1'b0, 4'b0000);
    check("t6_idle_gnt", 32'(gnt), 32'd0);
    check("t6_idle_out", 32'(out), 32'd0);
    check("t6_idle_state", 32'(dbg_busy), 32'd0);
    step("t6", 1'b0, 4'b1000);
    check("t6_gnt_d", 32'(gnt), 32'b1000);
    check("t6_sel_d", 32'(sel), 32'd3);
    check("t6_out_d", 32'(out), 32'd2);
    d = 5'd17;
    #1;
    check("t6_data_follow", 32'(out), 32'd17);

    // 7: random traffic with sticky requests and occasional reset
    rq = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      c = WIDTH'($urandom); d = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 39) == 0);
      step("rand", rr, rq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
